ps2_scan_decoder: RTL
=====================

Name: ps2_scan_decoder

Overview:
- Sits directly downstream of the PS/2 receiver. Consumes its byte strobe (rx_listo), data byte and start-bit sample (garg).
- Assembles raw scancode bytes into key events: prefix E0 marks an extended key, prefix F0 marks a break (key release).
- Buffers completed events in a small FIFO for the application logic (display/control FSM).
- Gates the receiver's rx_en to block new frames while the FIFO is full.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- TIMEOUT_CYC, 100000, clk_i cycles allowed between a prefix byte and the byte that follows it (2 ms at 50 MHz).
- CNT_W, 17, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-low reset
- rx_listo_i  in  1  one-cycle byte-ready strobe from the receiver
- data_i  in  8  received byte; valid when rx_listo_i=1
- garg_i  in  1  received start bit; must be 0 for a valid frame
- rx_en_o  out  1  receive enable to the receiver
- ev_valid_o  out  1  FIFO not empty
- ev_code_o  out  8  head event scancode
- ev_ext_o  out  1  head event is extended (E0 seen)
- ev_brk_o  out  1  head event is a break (F0 seen)
- ev_rd_i  in  1  pop head event; ignored when FIFO empty
- ovf_o  out  1  sticky overflow flag
- clr_i  in  1  synchronous clear of ovf_o
- err_o  out  1  one-cycle pulse on framing error or prefix timeout

Behaviour:
- Reset (rst_i=0): FSM=S_IDLE; FIFO empty; pointers and count 0; timeout counter 0. Outputs: ovf_o=0, err_o=0, ev_valid_o=0, ev_code_o/ev_ext_o/ev_brk_o=0, rx_en_o=1.
- Reset asserted mid-sequence discards any pending prefix and all buffered events.
- Byte acceptance: a byte is accepted on a clk_i edge with rx_listo_i=1.
- If garg_i=1 on that edge: byte dropped, err_o=1 next cycle, FSM returns to S_IDLE.
- FSM states S_IDLE, S_EXT, S_BRK, S_EXT_BRK. Transitions on an accepted byte b:
  - S_IDLE: b=E0 -> S_EXT; b=F0 -> S_BRK; b in {00,AA,EE,FA,FE,FF} -> dropped, stay S_IDLE (keyboard control responses); any other b -> push {ext=0,brk=0,b}, stay S_IDLE.
  - S_EXT: b=F0 -> S_EXT_BRK; b=E0 -> stay S_EXT; other -> push {1,0,b}, -> S_IDLE.
  - S_BRK: b=F0 -> stay S_BRK; b=E0 -> S_EXT_BRK; other -> push {0,1,b}, -> S_IDLE.
  - S_EXT_BRK: b=E0 or F0 -> stay; other -> push {1,1,b}, -> S_IDLE.
- Timeout:
  - Counter clears on every accepted byte and holds 0 in S_IDLE.
  - Counter increments each cycle in the three prefix states.
  - Reaching TIMEOUT_CYC-1 -> S_IDLE, err_o pulse, counter 0. No event pushed.
- FIFO:
  - Push latency: the event is visible on ev_* with ev_valid_o=1 on the cycle after the rx_listo_i edge.
  - Outputs are show-ahead: ev_* reflect the head entry combinationally from storage.
  - Pop on ev_rd_i=1 with ev_valid_o=1; the next entry appears the following cycle.
- FIFO boundary conditions:
  - Push while full and no pop: event dropped, ovf_o set (sticky).
  - Push and pop in the same cycle when full: both succeed, count unchanged, ovf_o unchanged.
  - Push and pop in the same cycle when empty: push only.
  - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- ovf_o: cleared by clr_i=1. If clr_i and a new overflow occur in the same cycle, the set wins.
- rx_en_o = ~full, registered. It deasserts the cycle after count reaches DEPTH and reasserts the cycle after a pop from full.

Decomposition:
- Package ps2_pkg holds:
  - byte constants: PS2_EXT=E0, PS2_BRK=F0, PS2_ACK=FA, PS2_BAT=AA, PS2_ECHO=EE, PS2_RESEND=FE, PS2_ERR0=00, PS2_ERR1=FF;
  - FSM state encoding (2 bits);
  - event word layout {ext,brk,code[7:0]} = 10 bits.
- One sub-module, ps2_ev_fifo: parameterised DEPTH × 10-bit synchronous FIFO with push, pop, full, empty, show-ahead output. The decoder FSM, timeout counter and ovf/err logic stay in the top.

Test Plan:
- Bytes 1C; then F0,1C -> events {0,0,1C} then {0,1,1C}; err_o never pulses.
- Bytes E0,75; then E0,F0,75 -> events {1,0,75} then {1,1,75}.
- Byte FA, then AA -> no event, ev_valid_o stays 0. Then byte 1C with garg_i=1 -> no event, err_o one-cycle pulse.
- Byte F0, then idle TIMEOUT_CYC cycles, then byte 1C -> err_o pulses once. The single event pushed is {0,0,1C} (prefix discarded).
- With DEPTH=4, push 5 make codes 15,1D,24,2D,2C without ev_rd_i:
  - rx_en_o=0 after the 4th push; ovf_o=1 after the 5th; FIFO holds 15,1D,24,2D.
  - Then pulse clr_i -> ovf_o=0.
  - Then pop once -> head 1D; rx_en_o=1 next cycle.
- With FIFO full, push 3C and assert ev_rd_i in the same cycle -> count stays 4, ovf_o stays 0, tail entry is 3C. Then pulse rst_i=0 mid F0 prefix -> all outputs return to reset values.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scancode decoder: prefix/control bytes,
// decoder state encoding and the buffered event word layout.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  localparam int unsigned EV_W = 10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_ev_t;

  // Keyboard responses to host commands; never part of a key event.
  function automatic logic is_ctrl_byte(input logic [7:0] b);
    return b inside {PS2_ERR0, PS2_BAT, PS2_ECHO, PS2_ACK, PS2_RESEND, PS2_ERR1};
  endfunction

endpackage

// File: rtl/ps2_ev_fifo.sv
// Synchronous show-ahead FIFO for decoded key events. Push while full succeeds only
// when a pop happens in the same cycle; pop while empty is ignored.
module ps2_ev_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// Turns raw PS/2 scancode bytes into {ext, brk, code} key events, buffers them, and
// throttles the receiver while the event buffer is full.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_listo_i,
  input  logic [7:0] data_i,
  input  logic       garg_i,
  output logic       rx_en_o,
  output logic       ev_valid_o,
  output logic [7:0] ev_code_o,
  output logic       ev_ext_o,
  output logic       ev_brk_o,
  input  logic       ev_rd_i,
  output logic       ovf_o,
  input  logic       clr_i,
  output logic       err_o
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  ps2_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             rx_en_q;
  logic             push;
  ps2_ev_t          push_ev;
  logic [EV_W-1:0]  head_raw;
  ps2_ev_t          head;
  logic             full, empty, pop;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    push    = 1'b0;
    push_ev = '{ext: 1'b0, brk: 1'b0, code: data_i};
    if (rx_listo_i) begin
      cnt_d = '0;
      if (garg_i) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (data_i == PS2_EXT)      state_d = S_EXT;
            else if (data_i == PS2_BRK) state_d = S_BRK;
            else if (!is_ctrl_byte(data_i)) push = 1'b1;
          end
          S_EXT: begin
            if (data_i == PS2_BRK) state_d = S_EXT_BRK;
            else if (data_i != PS2_EXT) begin
              push        = 1'b1;
              push_ev.ext = 1'b1;
              state_d     = S_IDLE;
            end
          end
          S_BRK: begin
            if (data_i == PS2_EXT) state_d = S_EXT_BRK;
            else if (data_i != PS2_BRK) begin
              push        = 1'b1;
              push_ev.brk = 1'b1;
              state_d     = S_IDLE;
            end
          end
          S_EXT_BRK: begin
            if (data_i != PS2_EXT && data_i != PS2_BRK) begin
              push        = 1'b1;
              push_ev.ext = 1'b1;
              push_ev.brk = 1'b1;
              state_d     = S_IDLE;
            end
          end
        endcase
      end
    end else if (state_q != S_IDLE) begin
      // A prefix left dangling too long is abandoned without producing an event.
      if (cnt_q == TO_LAST) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign pop = ev_rd_i && !empty;

  always_comb begin
    ovf_d = ovf_q;
    if (clr_i) ovf_d = 1'b0;
    if (push && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      rx_en_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      rx_en_q <= ~full;
    end
  end

  ps2_ev_fifo #(
    .DEPTH (DEPTH),
    .W     (EV_W)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .push  (push),
    .wdata (push_ev),
    .pop   (ev_rd_i),
    .rdata (head_raw),
    .full  (full),
    .empty (empty)
  );

  // Storage is not reset, so the head is masked while the buffer is empty.
  assign head       = empty ? '0 : ps2_ev_t'(head_raw);
  assign ev_valid_o = ~empty;
  assign ev_code_o  = head.code;
  assign ev_ext_o   = head.ext;
  assign ev_brk_o   = head.brk;
  assign ovf_o      = ovf_q;
  assign err_o      = err_q;
  assign rx_en_o    = rx_en_q;

endmodule
